// File: rtl/mc_if.sv
// mc_if: instruction fields in, per-cycle datapath controls out of the multicycle control unit
interface mc_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic [1:0] FlagW;
  logic       IRWrite;
  logic       NextPC;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUControl;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  modport master (
    output Op, Funct, Rd,
    input  PCS, RegW, MemW, FlagW, IRWrite, NextPC, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
  );
  modport slave (
    input  Op, Funct, Rd,
    output PCS, RegW, MemW, FlagW, IRWrite, NextPC, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
  );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: Moore FSM plus ALU/field decoders producing multicycle datapath controls
module mc_controller (
  input  logic clk,
  input  logic rst,
  mc_if.slave  bus
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
  } state_t;
  state_t     r_state, w_next;
  logic       w_irw, w_npc, w_adrsrc, w_srca, w_regw, w_memw, w_branch, w_aluop, w_known;
  logic [1:0] w_ressrc, w_srcb, w_alu, w_flagw;
  logic [3:0] w_cmd;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  always_comb begin
    w_next   = S_FETCH;
    w_irw    = 1'b0;
    w_npc    = 1'b0;
    w_adrsrc = 1'b0;
    w_ressrc = 2'b00;
    w_srca   = 1'b0;
    w_srcb   = 2'b00;
    w_regw   = 1'b0;
    w_memw   = 1'b0;
    w_branch = 1'b0;
    w_aluop  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irw    = 1'b1;
        w_npc    = 1'b1;
        w_srca   = 1'b1;
        w_srcb   = 2'b10;
        w_ressrc = 2'b10;
        w_next   = S_DECODE;
      end
      S_DECODE: begin
        w_srca   = 1'b1;
        w_srcb   = 2'b10;
        w_ressrc = 2'b10;
        w_next   = bus.Op == 2'b00 ? (bus.Funct[5] ? S_EXECUTEI : S_EXECUTER) :
                   bus.Op == 2'b01 ? S_MEMADR :
                   bus.Op == 2'b10 ? S_BRANCH : S_FETCH;
      end
      S_MEMADR: begin
        w_srcb = 2'b01;
        w_next = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_adrsrc = 1'b1;
        w_next   = S_MEMWB;
      end
      S_MEMWB: begin
        w_ressrc = 2'b01;
        w_regw   = 1'b1;
      end
      S_MEMWR: begin
        w_adrsrc = 1'b1;
        w_memw   = 1'b1;
      end
      S_EXECUTER: begin
        w_aluop = 1'b1;
        w_next  = S_ALUWB;
      end
      S_EXECUTEI: begin
        w_srcb  = 2'b01;
        w_aluop = 1'b1;
        w_next  = S_ALUWB;
      end
      S_ALUWB: w_regw = 1'b1;
      S_BRANCH: begin
        w_srcb   = 2'b01;
        w_ressrc = 2'b10;
        w_branch = 1'b1;
      end
      default: ;
    endcase
  end
  assign w_cmd   = bus.Funct[4:1];
  assign w_known = w_cmd == 4'b0100 || w_cmd == 4'b0010 || w_cmd == 4'b0000 || w_cmd == 4'b1100;
  assign w_alu   = !w_aluop ? 2'b00 :
                   w_cmd == 4'b0010 ? 2'b01 :
                   w_cmd == 4'b0000 ? 2'b10 :
                   w_cmd == 4'b1100 ? 2'b11 : 2'b00;
  assign w_flagw = (w_aluop && w_known) ?
                   {bus.Funct[0], bus.Funct[0] & (w_cmd == 4'b0100 || w_cmd == 4'b0010)} : 2'b00;
  assign bus.IRWrite    = w_irw & ~rst;
  assign bus.NextPC     = w_npc & ~rst;
  assign bus.RegW       = w_regw & ~rst;
  assign bus.MemW       = w_memw & ~rst;
  assign bus.PCS        = ((w_regw & (bus.Rd == 4'hF)) | w_branch) & ~rst;
  assign bus.FlagW      = rst ? 2'b00 : w_flagw;
  assign bus.AdrSrc     = w_adrsrc;
  assign bus.ResultSrc  = w_ressrc;
  assign bus.ALUSrcA    = w_srca;
  assign bus.ALUSrcB    = w_srcb;
  assign bus.ALUControl = w_alu;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed plus random instruction stream checked against a per-cycle instruction model
module tb_mc_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int failed = 0;
  mc_if bus();
  mc_controller dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [18:0] w_obs;
  assign w_obs = {bus.PCS, bus.RegW, bus.MemW, bus.FlagW, bus.IRWrite, bus.NextPC, bus.AdrSrc,
                  bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.RegSrc};
  function automatic int ncyc(logic [1:0] op, logic [5:0] f);
    return op == 2'b00 ? 4 : op == 2'b01 ? (f[0] ? 5 : 4) : op == 2'b10 ? 3 : 2;
  endfunction
  function automatic logic [18:0] model(logic [1:0] op, logic [5:0] f, logic [3:0] rd, int idx, logic in_rst);
    logic pcs, regw, memw, irw, npc, adr, srca;
    logic [1:0] flagw, res, srcb, alu;
    logic [3:0] cmd;
    logic known;
    pcs = 0; regw = 0; memw = 0; irw = 0; npc = 0; adr = 0; srca = 0;
    flagw = 0; res = 0; srcb = 0; alu = 0;
    cmd = f[4:1];
    known = cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100};
    if (idx <= 1) begin
      srca = 1; srcb = 2'b10; res = 2'b10;
      irw = (idx == 0) && !in_rst;
      npc = irw;
    end else if (op == 2'b00 && idx == 2) begin
      srcb = f[5] ? 2'b01 : 2'b00;
      alu = cmd == 4'b0010 ? 2'b01 : cmd == 4'b0000 ? 2'b10 : cmd == 4'b1100 ? 2'b11 : 2'b00;
      flagw = known ? {f[0], f[0] & (cmd == 4'b0100 || cmd == 4'b0010)} : 2'b00;
    end else if ((op == 2'b00 && idx == 3) || (op == 2'b01 && f[0] && idx == 4)) begin
      regw = 1; res = (op == 2'b01) ? 2'b01 : 2'b00; pcs = (rd == 4'hF);
    end else if (op == 2'b01 && idx == 2) begin
      srcb = 2'b01;
    end else if (op == 2'b01 && idx == 3) begin
      adr = 1; memw = !f[0];
    end else if (op == 2'b10 && idx == 2) begin
      srcb = 2'b01; res = 2'b10; pcs = 1;
    end
    return {pcs, regw, memw, flagw, irw, npc, adr, res, srca, srcb, alu, op, {op == 2'b01, op == 2'b10}};
  endfunction
  task automatic check(string tag, logic [18:0] obs, logic [18:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run_instr(string tag, logic [1:0] op, logic [5:0] f, logic [3:0] rd, int rst_at);
    bus.Op = op; bus.Funct = f; bus.Rd = rd;
    for (int i = 0; i < ncyc(op, f); i++) begin
      @(negedge clk);
      check($sformatf("%s c%0d", tag, i), w_obs, model(op, f, rd, i, 1'b0));
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        check($sformatf("%s rst", tag), w_obs, model(op, f, rd, 0, 1'b1));
        @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    bus.Op = 2'b01; bus.Funct = 6'b000000; bus.Rd = 4'h3;
    @(negedge clk);
    check("reset0", w_obs, model(2'b01, 6'b000000, 4'h3, 0, 1'b1));
    @(negedge clk);
    check("reset1", w_obs, model(2'b01, 6'b000000, 4'h3, 0, 1'b1));
    @(posedge clk);
    #1 rst = 1'b0;
    run_instr("adds_imm", 2'b00, 6'b101001, 4'h1, -1);
    run_instr("ands_reg", 2'b00, 6'b000001, 4'h2, -1);
    run_instr("orr_pc",   2'b00, 6'b011000, 4'hF, -1);
    run_instr("subs_reg", 2'b00, 6'b000101, 4'h4, -1);
    run_instr("ldr",      2'b01, 6'b011001, 4'h5, -1);
    run_instr("ldr_pc",   2'b01, 6'b010001, 4'hF, -1);
    run_instr("str",      2'b01, 6'b011000, 4'h6, -1);
    run_instr("b",        2'b10, 6'b100000, 4'h0, -1);
    run_instr("undef",    2'b11, 6'b111111, 4'hF, -1);
    run_instr("cmd1111",  2'b00, 6'b011111, 4'h7, -1);
    run_instr("str_rst",  2'b01, 6'b000000, 4'h8, 3);
    run_instr("post_rst", 2'b00, 6'b001001, 4'h9, -1);
    for (int n = 0; n < 150; n++) begin
      logic [1:0] op;
      logic [5:0] f;
      logic [3:0] cmd;
      op = 2'($urandom_range(0, 3));
      f = 6'($urandom);
      case ($urandom_range(0, 4))
        0: cmd = 4'b0100;
        1: cmd = 4'b0010;
        2: cmd = 4'b0000;
        3: cmd = 4'b1100;
        default: cmd = 4'($urandom);
      endcase
      if (op == 2'b00) f[4:1] = cmd;
      run_instr($sformatf("rnd%0d", n), op, f, ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom),
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 1)) : -1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the ARM-subset datapath: a Moore state machine plus ALU and instruction-field decoders that turn the latched instruction fields into per-cycle datapath controls. It is the producer of PCS, RegW, MemW and FlagW. The conditional-execution logic downstream gates these signals with the condition result before they reach the PC, register file, memory and flag registers. It sits between the instruction register and that conditional logic.

## Interface
Parameters: none.
- clk  in  1  system clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- Op  in  2  instr[27:26], stable from DECODE until the next FETCH
- Funct  in  6  instr[25:20]: [5]=I, [4:1]=cmd, [0]=S/L
- Rd  in  4  instr[15:12]
- PCS  out  1  PC written from Result (unconditioned)
- RegW  out  1  register-file write request (unconditioned)
- MemW  out  1  memory write request (unconditioned)
- FlagW  out  2  [1]=N,Z write, [0]=C,V write (unconditioned)
- IRWrite  out  1  instruction register load
- NextPC  out  1  PC load with PC+4 (unconditional)
- AdrSrc  out  1  0=PC, 1=ALUOut as memory address
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  0=RD1, 1=PC
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=const 4
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Outputs not listed for a state are 0.
- Internal Moore signals: Branch and ALUOp.
- FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state: DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state:
  - Op=00 and Funct[5]=1 → EXECUTEI
  - Op=00 and Funct[5]=0 → EXECUTER
  - Op=01 → MEMADR
  - Op=10 → BRANCH
  - Op=11 → FETCH (undefined instruction; no writes)
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0. Next: MEMRD if Funct[0]=1, else MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
- MEMWB: ResultSrc=01, RegW=1. Next: FETCH.
- MEMWR: AdrSrc=1, ResultSrc=00, MemW=1. Next: FETCH.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1. Next: ALUWB.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1. Next: ALUWB.
- ALUWB: ResultSrc=00, RegW=1. Next: FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1. Next: FETCH.
- PCS = (RegW & Rd==4'hF) | Branch.
- ALU decode when ALUOp=1 (cmd = Funct[4:1]):
  - 0100 → 00 (ADD); 0010 → 01 (SUB); 0000 → 10 (AND); 1100 → 11 (ORR).
  - Any other cmd → ALUControl=00, FlagW=00. The instruction completes as ADD (write-back still occurs).
  - FlagW[1] = Funct[0].
  - FlagW[0] = Funct[0] & (cmd is ADD or SUB).
- ALUOp=0: ALUControl=00 and FlagW=00. Flags can therefore change only in EXECUTER/EXECUTEI.
- Unreachable state encodings → FETCH on the next edge, with all outputs 0.

## Timing
- Next-state register only; all outputs are combinational from state, Op, Funct and Rd.
- rst asserted: state forced to FETCH immediately, without waiting for a clock edge.
- While rst is high: IRWrite, NextPC, RegW, MemW, PCS and FlagW are forced to 0. The other outputs take their FETCH values.
- First FETCH executes in the first cycle after rst deasserts.
- Cycles per instruction, FETCH inclusive: data-processing 4, LDR 5, STR 4, B 3, undefined (Op=11) 2.
- rst asserted mid-instruction (e.g. in MEMWR): the write enables drop in the same cycle, and execution restarts at FETCH.

## Test plan
- Reset: hold rst=1, then release → state=FETCH, all write enables 0 during reset. First cycle after release: IRWrite=1, NextPC=1, ALUSrcB=10.
- ADDS R1,R2,#5 (Op=00, Funct=101001, Rd=1) → states F,D,EXECUTEI,ALUWB. EXECUTEI: ALUControl=00, FlagW=11, ALUSrcB=01. ALUWB: RegW=1, PCS=0.
- ANDS register form (Funct=000001) → FlagW=10 in EXECUTER. ORR with Rd=15 (Funct=011000) → ALUWB has RegW=1 and PCS=1.
- LDR (Op=01, Funct[0]=1) → F,D,MEMADR,MEMRD,MEMWB. AdrSrc=1 in MEMRD; ResultSrc=01 and RegW=1 in MEMWB. STR (Funct[0]=0) → MemW=1 only in MEMWR; 4 cycles total.
- B (Op=10) → BRANCH: PCS=1, ALUSrcB=01, ResultSrc=10, then FETCH. Op=11 → DECODE→FETCH with no write enable ever high.
- rst pulsed mid-cycle while in MEMWR → MemW falls before the next clock edge. First cycle after release is FETCH. Unsupported cmd 1111 → ALUControl=00, FlagW=00.
